alu_seq: RTL and testbench

Sequential ALU stage directly upstream of the accumulator register. It takes operand A from the accumulator output and operand B from the operand bus. It executes one operation per start request and drives the accumulator's data input with a one-cycle write strobe. Single-cycle logic/arithmetic ops and an optional 8-cycle shift-add multiply share one handshake, so the control unit sees a uniform start/done interface.

---
 rtl/alu_seq.sv | 181 ++++++++++++++++++
 tb/tb_alu_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU feeding the accumulator: single-cycle ops plus shift-add multiply.
// Optional multiplier is compiled only when ALU_MUL_EN is defined.
module alu_seq #(
    parameter int WIDTH      = 8,
    parameter int MUL_CYCLES = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] alu_out,
    output logic             en_da,
    output logic             done,
    output logic             busy,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    // Only the 8-bit datapath with an 8-step multiply is supported.
    if (WIDTH != 8 || MUL_CYCLES != WIDTH) begin : g_bad_cfg
        $error("alu_seq: WIDTH and MUL_CYCLES must both be 8");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_alu_out;
    logic             r_en_da;
    logic             r_done;
    logic             r_busy;
    logic             r_carry;
    logic             r_zero;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [WIDTH-1:0] w_res;
    logic             w_cy;

    assign w_sum = {1'b0, a_in} + {1'b0, b_in};
    assign w_dif = {1'b0, a_in} - {1'b0, b_in};

    always_comb begin
        w_res = '0;
        w_cy  = 1'b0;
        case (op)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_cy  = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res = w_dif[WIDTH-1:0];
                w_cy  = w_dif[WIDTH];
            end
            OP_AND: w_res = a_in & b_in;
            OP_OR:  w_res = a_in | b_in;
            OP_XOR: w_res = a_in ^ b_in;
            OP_SHL: begin
                w_res = {a_in[WIDTH-2:0], 1'b0};
                w_cy  = a_in[WIDTH-1];
            end
            OP_SHR: begin
                w_res = {1'b0, a_in[WIDTH-1:1]};
                w_cy  = a_in[0];
            end
            default: begin
                w_res = '0;
                w_cy  = 1'b0;
            end
        endcase
    end

`ifdef ALU_MUL_EN
    localparam logic [3:0] LP_LAST = 4'(MUL_CYCLES - 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic [2*WIDTH-1:0] r_prod;
    logic [3:0]         r_cnt;
    logic [2*WIDTH-1:0] w_prod_nxt;

    // Multiplicand shifts left and multiplier right, so bit 0 is always current.
    assign w_prod_nxt = r_prod + (r_mplr[0] ? r_mcand : '0);
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= S_IDLE;
            r_alu_out <= '0;
            r_en_da   <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
`ifdef ALU_MUL_EN
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_prod    <= '0;
            r_cnt     <= '0;
`endif
        end else begin
            r_en_da <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (op == OP_MUL) begin
`ifdef ALU_MUL_EN
                            r_mcand <= {{WIDTH{1'b0}}, a_in};
                            r_mplr  <= b_in;
                            r_prod  <= '0;
                            r_cnt   <= '0;
                            r_state <= S_MUL;
`else
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
`endif
                        end else begin
                            r_alu_out <= w_res;
                            r_carry   <= w_cy;
                            r_zero    <= (w_res == '0);
                            r_en_da   <= 1'b1;
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
`ifdef ALU_MUL_EN
                    r_prod  <= w_prod_nxt;
                    r_mcand <= {r_mcand[2*WIDTH-2:0], 1'b0};
                    r_mplr  <= {1'b0, r_mplr[WIDTH-1:1]};
                    r_cnt   <= r_cnt + 4'd1;
                    if (r_cnt == LP_LAST) begin
                        r_alu_out <= w_prod_nxt[WIDTH-1:0];
                        r_carry   <= |w_prod_nxt[2*WIDTH-1:WIDTH];
                        r_zero    <= (w_prod_nxt[WIDTH-1:0] == '0);
                        r_en_da   <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
`else
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
`endif
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_out = r_alu_out;
    assign en_da   = r_en_da;
    assign done    = r_done;
    assign busy    = r_busy;
    assign carry   = r_carry;
    assign zero    = r_zero;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq; covers both ALU_MUL_EN builds.
module tb_alu_seq;

    logic       clk;
    logic       clr;
    logic       start;
    logic [2:0] op;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [7:0] alu_out;
    logic       en_da;
    logic       done;
    logic       busy;
    logic       carry;
    logic       zero;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(8), .MUL_CYCLES(8)) dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .op      (op),
        .a_in    (a_in),
        .b_in    (b_in),
        .alu_out (alu_out),
        .en_da   (en_da),
        .done    (done),
        .busy    (busy),
        .carry   (carry),
        .zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle start; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = 8'h00;
        b_in  = 8'h00;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;
        clr   = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        a_in  = 8'h00;
        b_in  = 8'h00;
        step();
        step();
        chk("rst_alu_out", 16'(alu_out), 16'h00);
        chk("rst_en_da",   16'(en_da),   16'h0);
        chk("rst_done",    16'(done),    16'h0);
        chk("rst_busy",    16'(busy),    16'h0);
        chk("rst_carry",   16'(carry),   16'h0);
        chk("rst_zero",    16'(zero),    16'h0);
        clr = 1'b0;
        step();

        issue(3'b000, 8'hF0, 8'h20);
        chk("add_out",   16'(alu_out), 16'h10);
        chk("add_carry", 16'(carry),   16'h1);
        chk("add_zero",  16'(zero),    16'h0);
        chk("add_en",    16'(en_da),   16'h1);
        chk("add_done",  16'(done),    16'h1);
        chk("add_busy",  16'(busy),    16'h1);
        step();
        chk("add_en_off",   16'(en_da),   16'h0);
        chk("add_done_off", 16'(done),    16'h0);
        chk("add_busy_off", 16'(busy),    16'h0);
        chk("add_hold",     16'(alu_out), 16'h10);

        issue(3'b001, 8'h05, 8'h05);
        chk("sub0_out",   16'(alu_out), 16'h00);
        chk("sub0_zero",  16'(zero),    16'h1);
        chk("sub0_carry", 16'(carry),   16'h0);
        step();

        issue(3'b001, 8'h03, 8'h05);
        chk("subb_out",   16'(alu_out), 16'hFE);
        chk("subb_carry", 16'(carry),   16'h1);
        chk("subb_zero",  16'(zero),    16'h0);
        step();

        issue(3'b010, 8'hF0, 8'h3C);
        chk("and_out",   16'(alu_out), 16'h30);
        chk("and_carry", 16'(carry),   16'h0);
        step();
        issue(3'b011, 8'hF0, 8'h0F);
        chk("or_out", 16'(alu_out), 16'hFF);
        step();
        issue(3'b100, 8'hAA, 8'hFF);
        chk("xor_out", 16'(alu_out), 16'h55);
        step();

        issue(3'b101, 8'h81, 8'h00);
        chk("shl_out",   16'(alu_out), 16'h02);
        chk("shl_carry", 16'(carry),   16'h1);
        step();
        issue(3'b110, 8'h81, 8'h00);
        chk("shr_out",   16'(alu_out), 16'h40);
        chk("shr_carry", 16'(carry),   16'h1);
        step();

        // Start held into DONE: the second edge must not launch another op.
        start = 1'b1;
        op    = 3'b000;
        a_in  = 8'h01;
        b_in  = 8'h01;
        step();
        chk("hold_first", 16'(alu_out), 16'h02);
        a_in = 8'h10;
        step();
        start = 1'b0;
        chk("hold_ign_en",   16'(en_da),   16'h0);
        chk("hold_ign_busy", 16'(busy),    16'h0);
        chk("hold_ign_out",  16'(alu_out), 16'h02);
        step();

`ifdef ALU_MUL_EN
        issue(3'b111, 8'h0C, 8'h0B);
        seen = 0;
        for (int i = 1; i < 8; i++) begin
            if (i == 3) begin
                start = 1'b1;
                op    = 3'b000;
                a_in  = 8'h55;
                b_in  = 8'h01;
            end
            if (en_da) seen++;
            chk("mul_busy", 16'(busy), 16'h1);
            step();
            start = 1'b0;
        end
        if (en_da) seen++;
        chk("mul_no_early_en", 16'(seen), 16'h0);
        step();
        chk("mul1_en",    16'(en_da),   16'h1);
        chk("mul1_done",  16'(done),    16'h1);
        chk("mul1_out",   16'(alu_out), 16'h84);
        chk("mul1_carry", 16'(carry),   16'h0);
        chk("mul1_zero",  16'(zero),    16'h0);
        step();
        chk("mul1_en_off", 16'(en_da), 16'h0);
        chk("mul1_idle",   16'(busy),  16'h0);

        issue(3'b111, 8'h33, 8'h07);
        step();
        step();
        clr = 1'b1;
        #1;
        chk("clr_mid_out",  16'(alu_out), 16'h00);
        chk("clr_mid_busy", 16'(busy),    16'h0);
        chk("clr_mid_en",   16'(en_da),   16'h0);
        step();
        clr  = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (en_da || busy) seen++;
            step();
        end
        chk("clr_no_pulse", 16'(seen), 16'h0);

        issue(3'b111, 8'h20, 8'h10);
        for (int i = 1; i < 8; i++) step();
        step();
        chk("mul2_en",    16'(en_da),   16'h1);
        chk("mul2_out",   16'(alu_out), 16'h00);
        chk("mul2_carry", 16'(carry),   16'h1);
        chk("mul2_zero",  16'(zero),    16'h1);
        step();
`else
        issue(3'b110, 8'h81, 8'h00);
        step();
        issue(3'b111, 8'h0C, 8'h0B);
        chk("nomul_done",  16'(done),    16'h1);
        chk("nomul_en",    16'(en_da),   16'h0);
        chk("nomul_busy",  16'(busy),    16'h1);
        chk("nomul_out",   16'(alu_out), 16'h40);
        chk("nomul_carry", 16'(carry),   16'h1);
        chk("nomul_zero",  16'(zero),    16'h0);
        step();
        chk("nomul_done_off", 16'(done), 16'h0);
        chk("nomul_idle",     16'(busy), 16'h0);

        issue(3'b000, 8'h11, 8'h22);
        clr = 1'b1;
        #1;
        chk("clr_mid_out",  16'(alu_out), 16'h00);
        chk("clr_mid_busy", 16'(busy),    16'h0);
        chk("clr_mid_en",   16'(en_da),   16'h0);
        step();
        clr  = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (en_da || busy) seen++;
            step();
        end
        chk("clr_no_pulse", 16'(seen), 16'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
